fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares one sync_FIFO write port between NUM_REQ producers.
- Grants one requester at a time for a burst of up to BURST_LEN beats.
- Drives the FIFO's wr_cs, wr_en and data_in, and stalls the owner while the FIFO reports full.
- Sits directly in front of sync_FIFO, one clock domain.

---
 rtl/fifo_wr_arbiter.sv | 154 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one sync_FIFO write port
// between NUM_REQ producers. A grant lasts up to BURST_LEN beats. The owner
// stalls while the FIFO is full. At least one idle cycle separates bursts.
// Optional feature: define FIFO_WR_ARB_STALL_CNT_EN to add a saturating
// 16-bit stall_cnt output. It counts cycles where the owner wanted to write
// but the FIFO was full.

// Per-lane gating: the accept strobe and data contribution for one requester.
module fifo_wr_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  gnt,
  input  logic                  beat,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  accept,
  output logic [DATA_WIDTH-1:0] data_gated
);
  assign accept     = gnt & beat;
  assign data_gated = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            accept,
  output logic                          fifo_wr_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                               state;
  logic   [PW-1:0]                      ptr;
  logic   [PW-1:0]                      owner;
  logic   [CW-1:0]                      beat_cnt;
  logic   [PW-1:0]                      sel;
  logic                                 sel_vld;
  logic   [PW-1:0]                      ptr_nxt;
  logic                                 owner_req;
  logic                                 beat;
  logic                                 burst_end;
  int                                   idx;
  logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
  logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_gated;

  assign lane_data = req_data;

  // gnt is one-hot on the owner during BURST, so masking req with it picks req[owner]
  assign owner_req = |(req & gnt);
  assign busy      = (state == BURST);
  assign beat      = busy & owner_req & ~fifo_full;
  assign burst_end = busy & (~owner_req | (beat & (beat_cnt == LAST_BEAT)));
  assign ptr_nxt   = (owner == LAST_REQ) ? '0 : owner + PW'(1);

  assign fifo_wr_cs = busy;
  assign fifo_wr_en = beat;

  // Round-robin search starting at ptr. The lowest offset wins, so iterate from the top down.
  always_comb begin
    sel     = ptr;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        sel     = PW'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_lane
      fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .gnt       (gnt[i]),
        .beat      (beat),
        .data      (lane_data[i]),
        .accept    (accept[i]),
        .data_gated(lane_gated[i])
      );
    end
  endgenerate

  // AND-OR data mux: at most one lane is granted. With no grant, the output is zero (IDLE).
  always_comb begin
    fifo_data_in = '0;
    for (int k = 0; k < NUM_REQ; k++) fifo_data_in = fifo_data_in | lane_gated[k];
  end

  // Arbitration FSM: IDLE picks an owner, BURST streams beats until the count is done or the owner releases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            owner    <= sel;
            gnt      <= NUM_REQ'(1) << sel;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            gnt      <= '0;
            beat_cnt <= '0;
            ptr      <= ptr_nxt;
          end else if (beat) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  // Count owner cycles blocked by a full FIFO. The count saturates and is cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (busy && owner_req && fifo_full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. Directed scenarios follow the intended use
// cases. A long randomized run is compared against an abstract
// owner/pointer/count model of the arbitration rules.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic          fifo_full = 1'b0;
  logic [N-1:0]  gnt, accept;
  logic          fifo_wr_cs, fifo_wr_en, busy;
  logic [DW-1:0] fifo_data_in;

  logic [1:0]    req2 = '0;
  logic [15:0]   req_data2 = 16'hB7A3;
  logic          full2 = 1'b0;
  logic [1:0]    gnt2, acc2;
  logic          cs2, en2, busy2;
  logic [7:0]    d2;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0]   stall_cnt, stall_cnt2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .gnt(gnt), .accept(accept), .fifo_wr_cs(fifo_wr_cs), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .busy(busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Two-requester, single-beat instance for the minimum-size corner
  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .BURST_LEN(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .fifo_full(full2),
    .gnt(gnt2), .accept(acc2), .fifo_wr_cs(cs2), .fifo_wr_en(en2),
    .fifo_data_in(d2), .busy(busy2)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  // Reference model: who owns the port, how many beats it has written, and where the search starts
  int m_owner, m_ptr, m_cnt, m_stall;
  bit m_busy;

  function automatic int pick_req(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_owner <= 0; m_ptr <= 0; m_cnt <= 0; m_stall <= 0;
    end else if (!m_busy) begin
      if (pick_req(req, m_ptr) >= 0) begin
        m_busy <= 1; m_owner <= pick_req(req, m_ptr); m_cnt <= 0;
      end
    end else if (!req[m_owner]) begin
      m_busy <= 0; m_cnt <= 0; m_ptr <= (m_owner + 1) % N;
    end else if (fifo_full) begin
      if (m_stall < 65535) m_stall <= m_stall + 1;
    end else if (m_cnt + 1 == BL) begin
      m_busy <= 0; m_cnt <= 0; m_ptr <= (m_owner + 1) % N;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; req = '0; fifo_full = 1'b0; req2 = '0;
    nxt; nxt;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req = 4'b1111; req_data = 32'hFFFFFFFF; #2;
    nxt; @(negedge clk);
    n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    n_chk++; if (accept !== 4'b0) begin n_fail++; $display("FAIL reset_accept got %b exp 0000", accept); end
    n_chk++; if ({fifo_wr_cs, fifo_wr_en, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl cs/en/busy got %b exp 000", {fifo_wr_cs, fifo_wr_en, busy}); end
    n_chk++; if (fifo_data_in !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", fifo_data_in); end
    n_chk++; if (gnt2 !== 2'b00) begin n_fail++; $display("FAIL reset_gnt2 got %b exp 00", gnt2); end
  endtask

  task automatic test_single;
    do_reset;
    req = 4'b0010; req_data = 32'h0000A500;
    @(negedge clk);
    n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL single_latency gnt got %b exp 0000", gnt); end
    nxt;
    for (int j = 0; j < BL; j++) begin
      @(negedge clk);
      n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt beat %0d got %b exp 0010", j, gnt); end
      n_chk++; if (fifo_wr_en !== 1'b1 || accept !== 4'b0010) begin n_fail++; $display("FAIL single_beat %0d en %b acc %b exp 1 0010", j, fifo_wr_en, accept); end
      n_chk++; if (fifo_data_in !== 8'hA5) begin n_fail++; $display("FAIL single_data %0d got %h exp a5", j, fifo_data_in); end
      nxt;
    end
    @(negedge clk);
    n_chk++; if (gnt !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_gap gnt %b busy %b exp 0000 0", gnt, busy); end
    nxt; @(negedge clk);
    n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_regrant got %b exp 0010", gnt); end
  endtask

  task automatic test_all_req;
    do_reset;
    req = 4'b1111; req_data = 32'h40302010;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL allreq_gap %0d got %b exp 0000", b, gnt); end
      nxt;
      for (int j = 0; j < BL; j++) begin
        @(negedge clk);
        n_chk++; if (gnt !== 4'(1 << (b % N))) begin n_fail++; $display("FAIL allreq_gnt b%0d j%0d got %b exp %b", b, j, gnt, 4'(1 << (b % N))); end
        n_chk++; if (fifo_data_in !== 8'((b % N + 1) * 16) || fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL allreq_data b%0d j%0d got %h en %b", b, j, fifo_data_in, fifo_wr_en); end
        nxt;
      end
    end
  endtask

  task automatic test_early_release;
    do_reset;
    req = 4'b1100; req_data = 32'h44332211;
    nxt; nxt; nxt;
    req = 4'b1001;
    @(negedge clk);
    n_chk++; if (gnt !== 4'b0100 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL early_drop gnt %b en %b exp 0100 0", gnt, fifo_wr_en); end
    nxt; @(negedge clk);
    n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL early_gap got %b exp 0000", gnt); end
    nxt; @(negedge clk);
    n_chk++; if (gnt !== 4'b1000 || fifo_data_in !== 8'h44) begin n_fail++; $display("FAIL early_next gnt %b data %h exp 1000 44", gnt, fifo_data_in); end
  endtask

  task automatic test_full_stall;
    do_reset;
    req = 4'b0001; req_data = 32'h000000C3;
    nxt; nxt;
    fifo_full = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_chk++; if (fifo_wr_en !== 1'b0 || accept !== 4'b0 || gnt !== 4'b0001 || busy !== 1'b1) begin
        n_fail++; $display("FAIL stall_%0d en %b acc %b gnt %b busy %b exp 0 0000 0001 1", j, fifo_wr_en, accept, gnt, busy); end
      nxt;
    end
    fifo_full = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_chk++; if (fifo_wr_en !== 1'b1 || gnt !== 4'b0001) begin n_fail++; $display("FAIL stall_resume %0d en %b gnt %b exp 1 0001", j, fifo_wr_en, gnt); end
      nxt;
    end
    @(negedge clk);
    n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL stall_end got %b exp 0000", gnt); end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    n_chk++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
`endif
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 4'b0011; req_data = 32'h00005A66;
    for (int j = 0; j < 7; j++) nxt;
    @(negedge clk);
    n_chk++; if (gnt !== 4'b0010 || fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre gnt %b en %b exp 0010 1", gnt, fifo_wr_en); end
    #1 rst = 1'b0; #1;
    n_chk++; if (gnt !== 4'b0 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_async gnt %b busy %b en %b exp 0000 0 0", gnt, busy, fifo_wr_en); end
    nxt; rst = 1'b1;
    @(negedge clk);
    n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL rstmid_idle got %b exp 0000", gnt); end
    nxt; @(negedge clk);
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_restart got %b exp 0001", gnt); end
  endtask

  task automatic test_wrap;
    do_reset;
    req = 4'b0100; req_data = 32'h99000088;
    for (int j = 0; j < 5; j++) nxt;
    req = 4'b1001;
    @(negedge clk);
    n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL wrap_gap got %b exp 0000", gnt); end
    nxt; @(negedge clk);
    n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wrap_first got %b exp 1000", gnt); end
    for (int j = 0; j < 5; j++) nxt;
    @(negedge clk);
    n_chk++; if (gnt !== 4'b0001 || fifo_data_in !== 8'h88) begin n_fail++; $display("FAIL wrap_second gnt %b data %h exp 0001 88", gnt, fifo_data_in); end
    do_reset;
    req2 = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++; if (gnt2 !== ((c % 2 == 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10))) begin
        n_fail++; $display("FAIL wrap_n2 cycle %0d got %b", c, gnt2); end
      if (c % 2 == 1) begin
        n_chk++; if (en2 !== 1'b1 || d2 !== (((c / 2) % 2 == 0) ? 8'hA3 : 8'hB7)) begin n_fail++; $display("FAIL wrap_n2_data cycle %0d en %b data %h", c, en2, d2); end
      end
      nxt;
    end
    req2 = '0;
  endtask

  task automatic test_random;
    logic [N-1:0]  e_gnt, e_acc;
    logic [DW-1:0] e_data;
    bit            e_beat;
    do_reset;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      fifo_full = ($urandom_range(0, 3) == 0);
      req_data  = $urandom;
      rst       = ($urandom_range(0, 499) != 0);
      @(negedge clk);
      e_gnt  = m_busy ? 4'(1 << m_owner) : 4'b0;
      e_beat = m_busy && req[m_owner] && !fifo_full;
      e_acc  = e_beat ? e_gnt : 4'b0;
      e_data = m_busy ? req_data[m_owner*DW +: DW] : 8'h00;
      n_chk++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rand_gnt c%0d got %b exp %b", c, gnt, e_gnt); end
      n_chk++; if (accept !== e_acc) begin n_fail++; $display("FAIL rand_accept c%0d got %b exp %b", c, accept, e_acc); end
      n_chk++; if ({fifo_wr_cs, fifo_wr_en, busy} !== {m_busy, e_beat, m_busy}) begin
        n_fail++; $display("FAIL rand_ctl c%0d cs/en/busy got %b exp %b", c, {fifo_wr_cs, fifo_wr_en, busy}, {m_busy, e_beat, m_busy}); end
      n_chk++; if (fifo_data_in !== e_data) begin n_fail++; $display("FAIL rand_data c%0d got %h exp %h", c, fifo_data_in, e_data); end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      n_chk++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rand_stall c%0d got %0d exp %0d", c, stall_cnt, m_stall); end
`endif
      nxt;
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_req;
    test_early_release;
    test_full_stall;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
